// File: rtl/dpi_result_checker.sv
// dpi_result_checker
//   Compares two result streams, for example a reference model and a DPI
//   model. Each channel buffers {data, tag} entries in its own in-order FIFO.
//   On every edge where both FIFOs hold an entry, both heads are popped
//   together and compared.
//
//   A pair matches only when both the data and the tag are equal. The
//   checker counts matches and mismatches with saturating counters, keeps
//   sticky error flags, and captures the first mismatching pair.
//
// Ports
//   clk_i, rst_i                       clock; synchronous active-high reset
//   a_valid_i/a_ready_o/a_data_i/a_tag_i  channel A entry handshake + payload
//   b_valid_i/b_ready_o/b_data_i/b_tag_i  channel B entry handshake + payload
//   match_cnt_o, mismatch_cnt_o        saturating pair counters (CNT_W bits)
//   err_o, tag_err_o                   sticky mismatch / tag-difference flags
//   err_data_a_o, err_data_b_o, err_tag_o  first mismatching pair (A data,
//                                      B data, A tag)
//   idle_o                             both FIFOs empty

// Per-channel FIFO. Ready (~full_o) and empty_o depend only on registered
// occupancy, so no input ever reaches them combinationally.
module dpi_result_checker_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;

    // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_i) wptr <= wptr + 1'b1;
            if (pop_i)  rptr <= rptr + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wptr] <= din_i;
    end

    assign dout_o  = mem[rptr];
    assign full_o  = (cnt == (AW+1)'(DEPTH));
    assign empty_o = (cnt == '0);
endmodule

module dpi_result_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_valid_i,
    output logic             a_ready_o,
    input  logic [31:0]      a_data_i,
    input  logic [31:0]      a_tag_i,
    input  logic             b_valid_i,
    output logic             b_ready_o,
    input  logic [31:0]      b_data_i,
    input  logic [31:0]      b_tag_i,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic             err_o,
    output logic             tag_err_o,
    output logic [31:0]      err_data_a_o,
    output logic [31:0]      err_data_b_o,
    output logic [31:0]      err_tag_o,
    output logic             idle_o
);
    localparam int NUM_CH = 2;   // lane 0 = A, lane 1 = B

    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] data;
    } entry_t;

    entry_t [NUM_CH-1:0] din, dout;
    logic   [NUM_CH-1:0] valid, push, full, empty;
    logic                pop, is_match, tag_diff;

    assign valid   = {b_valid_i, a_valid_i};
    assign din[0]  = '{tag: a_tag_i, data: a_data_i};
    assign din[1]  = '{tag: b_tag_i, data: b_data_i};

    // Anything offered on a reset edge is dropped.
    assign push = valid & ~full & {NUM_CH{~rst_i}};

    // Pop both heads together, and only when both FIFOs are non-empty.
    // An entry pushed into an empty FIFO is therefore compared one edge
    // later at the earliest.
    assign pop = ~|empty;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        dpi_result_checker_fifo #(
            .DEPTH (DEPTH),
            .W     ($bits(entry_t))
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[ch]),
            .din_i   (din[ch]),
            .pop_i   (pop),
            .dout_o  (dout[ch]),
            .full_o  (full[ch]),
            .empty_o (empty[ch])
        );
    end

    assign is_match = (dout[0] == dout[1]);
    assign tag_diff = (dout[0].tag != dout[1].tag);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            match_cnt_o    <= '0;
            mismatch_cnt_o <= '0;
            err_o          <= 1'b0;
            tag_err_o      <= 1'b0;
            err_data_a_o   <= '0;
            err_data_b_o   <= '0;
            err_tag_o      <= '0;
        end else if (pop) begin
            if (is_match) begin
                if (match_cnt_o != '1) match_cnt_o <= match_cnt_o + 1'b1;
            end else begin
                if (mismatch_cnt_o != '1) mismatch_cnt_o <= mismatch_cnt_o + 1'b1;
                // Only the first mismatch is captured.
                if (!err_o) begin
                    err_o        <= 1'b1;
                    err_data_a_o <= dout[0].data;
                    err_data_b_o <= dout[1].data;
                    err_tag_o    <= dout[0].tag;
                end
            end
            if (tag_diff) tag_err_o <= 1'b1;
        end
    end

    assign a_ready_o = ~full[0];
    assign b_ready_o = ~full[1];
    assign idle_o    = &empty;
endmodule

// File: tb/tb_dpi_result_checker.sv
module tb_dpi_result_checker;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [31:0] a_data, a_tag, b_data, b_tag;

    logic        a_ready, b_ready, err, tag_err, idle;
    logic [15:0] match_cnt, mismatch_cnt;
    logic [31:0] err_data_a, err_data_b, err_tag;

    logic        s_a_ready, s_b_ready, s_err, s_tag_err, s_idle;
    logic [3:0]  s_match_cnt, s_mismatch_cnt;
    logic [31:0] s_err_data_a, s_err_data_b, s_err_tag;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dpi_result_checker #(.DEPTH(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_data_i(a_data), .a_tag_i(a_tag),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_data_i(b_data), .b_tag_i(b_tag),
        .match_cnt_o(match_cnt), .mismatch_cnt_o(mismatch_cnt),
        .err_o(err), .tag_err_o(tag_err),
        .err_data_a_o(err_data_a), .err_data_b_o(err_data_b), .err_tag_o(err_tag),
        .idle_o(idle)
    );

    // Narrow-counter copy fed the same stimulus, for saturation checks.
    dpi_result_checker #(.DEPTH(4), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_ready_o(s_a_ready), .a_data_i(a_data), .a_tag_i(a_tag),
        .b_valid_i(b_valid), .b_ready_o(s_b_ready), .b_data_i(b_data), .b_tag_i(b_tag),
        .match_cnt_o(s_match_cnt), .mismatch_cnt_o(s_mismatch_cnt),
        .err_o(s_err), .tag_err_o(s_tag_err),
        .err_data_a_o(s_err_data_a), .err_data_b_o(s_err_data_b), .err_tag_o(s_err_tag),
        .idle_o(s_idle)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // One edge; outputs are then read 1ns after it, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; a_tag = '0; b_data = '0; b_tag = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_pair(input logic [31:0] ad, input logic [31:0] bd,
                             input logic [31:0] at, input logic [31:0] bt);
        a_valid = 1'b1; a_data = ad; a_tag = at;
        b_valid = 1'b1; b_data = bd; b_tag = bt;
        tick();
        idle_in();
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_match",   32'(match_cnt), 0);
        chk("rst_mism",    32'(mismatch_cnt), 0);
        chk("rst_err",     32'(err), 0);
        chk("rst_tagerr",  32'(tag_err), 0);
        chk("rst_ardy",    32'(a_ready), 1);
        chk("rst_brdy",    32'(b_ready), 1);
        chk("rst_idle",    32'(idle), 1);
        chk("rst_eda",     err_data_a, 0);

        // Lockstep: 100 equal pairs, one per cycle
        for (int k = 0; k < 100; k++) begin
            a_valid = 1'b1; a_data = k; a_tag = k;
            b_valid = 1'b1; b_data = k; b_tag = k;
            tick();
            if (k == 50) chk("lock_ardy", 32'(a_ready), 1);
        end
        idle_in();
        tick();
        chk("lock_match",  32'(match_cnt), 100);
        chk("lock_mism",   32'(mismatch_cnt), 0);
        chk("lock_err",    32'(err), 0);
        chk("lock_idle",   32'(idle), 1);
        chk("lock_sat",    32'(s_match_cnt), 15);

        // Skew: fill A, stall an extra offer, then drain with B
        do_reset();
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1; a_data = 32'h100 + k; a_tag = k;
            tick();
        end
        chk("skew_ardy0",  32'(a_ready), 0);
        chk("skew_match0", 32'(match_cnt), 0);
        chk("skew_idle0",  32'(idle), 0);
        // Offered while full: must not be accepted or disturb stored data
        a_data = 32'hAAAA_AAAA; a_tag = 32'hAA;
        tick();
        tick();
        idle_in();
        for (int k = 0; k < 4; k++) begin
            b_valid = 1'b1; b_data = 32'h100 + k; b_tag = k;
            tick();
            // First B entry is compared one edge after it is accepted
            if (k == 0) chk("skew_lat", 32'(match_cnt), 0);
        end
        idle_in();
        tick();
        chk("skew_match",  32'(match_cnt), 4);
        chk("skew_mism",   32'(mismatch_cnt), 0);
        chk("skew_ardy1",  32'(a_ready), 1);
        chk("skew_idle1",  32'(idle), 1);

        // Mismatch capture: pairs 3 and 5 differ in data only
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k == 3)      push_pair(32'h7, 32'h8, 3, 3);
            else if (k == 5) push_pair(32'h50, 32'h51, 5, 5);
            else             push_pair(k, k, k, k);
        end
        tick();
        chk("mm_err",      32'(err), 1);
        chk("mm_eda",      err_data_a, 32'h7);
        chk("mm_edb",      err_data_b, 32'h8);
        chk("mm_etag",     err_tag, 32'h3);
        chk("mm_mism",     32'(mismatch_cnt), 2);
        chk("mm_match",    32'(match_cnt), 4);
        chk("mm_tagerr",   32'(tag_err), 0);

        // Tag error with equal data
        do_reset();
        push_pair(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h10, 32'h11);
        tick();
        chk("te_tagerr",   32'(tag_err), 1);
        chk("te_err",      32'(err), 1);
        chk("te_mism",     32'(mismatch_cnt), 1);
        chk("te_etag",     err_tag, 32'h10);
        chk("te_eda",      err_data_a, 32'hDEAD_BEEF);

        // Saturation of the 4-bit counter
        do_reset();
        for (int k = 0; k < 20; k++) push_pair(k, k, k, k);
        tick();
        chk("sat_narrow",  32'(s_match_cnt), 15);
        chk("sat_wide",    32'(match_cnt), 20);
        push_pair(32'h77, 32'h77, 1, 1);
        tick();
        chk("sat_stay",    32'(s_match_cnt), 15);

        // Reset mid-stream with A holding 3 entries
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1; a_data = k; a_tag = k;
            tick();
        end
        chk("mid_idle0",   32'(idle), 0);
        rst = 1'b1;        // a_valid still high: this offer must be dropped
        tick();
        rst = 1'b0;
        idle_in();
        chk("mid_idle1",   32'(idle), 1);
        chk("mid_match",   32'(match_cnt), 0);
        chk("mid_smatch",  32'(s_match_cnt), 0);
        chk("mid_ardy",    32'(a_ready), 1);
        b_valid = 1'b1; b_data = 32'h0; b_tag = 32'h0;
        tick();
        idle_in();
        tick();
        chk("mid_nocmp",   32'(match_cnt), 0);
        chk("mid_nomism",  32'(mismatch_cnt), 0);
        chk("mid_idle2",   32'(idle), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
